// File: rtl/lcd_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fill_scheduler
// Brief    : Two-requester round-robin solid-fill sequencer emitting the
//            CASET / RASET / RAMWR byte stream for a 160x80 ST7735-class panel.
// Revision : 1.0 - initial release
// ============================================================================

module lcd_fill_scheduler #(
    parameter int X_OFS  = 1,
    parameter int Y_OFS  = 26,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic [1:0]  req,
    input  logic [7:0]  r0_x0,
    input  logic [7:0]  r0_x1,
    input  logic [6:0]  r0_y0,
    input  logic [6:0]  r0_y1,
    input  logic [15:0] r0_color,
    input  logic [7:0]  r1_x0,
    input  logic [7:0]  r1_x1,
    input  logic [6:0]  r1_y0,
    input  logic [6:0]  r1_y1,
    input  logic [15:0] r1_color,
    output logic [1:0]  ack,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        busy,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    output logic        tx_last
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CHECK  = 4'd1,
        S_CMD_CA = 4'd2,
        S_PAR_CA = 4'd3,
        S_CMD_RA = 4'd4,
        S_PAR_RA = 4'd5,
        S_CMD_WR = 4'd6,
        S_PIX    = 4'd7,
        S_FINISH = 4'd8
    } state_t;

    localparam logic [7:0]  C_CMD_CASET = 8'h2A;
    localparam logic [7:0]  C_CMD_RASET = 8'h2B;
    localparam logic [7:0]  C_CMD_RAMWR = 8'h2C;
    localparam logic [8:0]  C_WIDTH     = 9'(WIDTH);
    localparam logic [7:0]  C_HEIGHT    = 8'(HEIGHT);
    localparam logic [15:0] C_X_OFS     = 16'(X_OFS);
    localparam logic [15:0] C_Y_OFS     = 16'(Y_OFS);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        win_q, win_d;
    logic [7:0]  x0_q, x0_d, x1_q, x1_d;
    logic [6:0]  y0_q, y0_d, y1_q, y1_d;
    logic [15:0] color_q, color_d;
    logic [1:0]  idx_q, idx_d;
    logic [14:0] pix_cnt_q, pix_cnt_d;
    logic [1:0]  ack_q, ack_d, gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_dc_q, tx_dc_d;
    logic        tx_last_q, tx_last_d;

    logic        w_sel;
    logic        w_accept;
    logic        w_bad;
    logic [15:0] w_xs0, w_xs1, w_ys0, w_ys1;
    logic [8:0]  w_cols;
    logic [7:0]  w_rows;
    logic [13:0] w_area;
    logic [14:0] w_pix_bytes;
    logic [14:0] w_rem;

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] par_byte(input logic [1:0] idx,
                                            input logic [15:0] s0,
                                            input logic [15:0] s1);
        case (idx)
            2'd0:    return s0[15:8];
            2'd1:    return s0[7:0];
            2'd2:    return s1[15:8];
            default: return s1[7:0];
        endcase
    endfunction

    // Both requesting: the round-robin pointer decides; otherwise the lone one wins.
    assign w_sel    = (req == 2'b11) ? rr_q : req[1];
    assign w_accept = tx_valid_q && tx_ready;

    assign w_bad = (x0_q > x1_q) || (y0_q > y1_q) ||
                   ({1'b0, x1_q} >= C_WIDTH) || ({1'b0, y1_q} >= C_HEIGHT);

    assign w_xs0 = {8'h00, x0_q} + C_X_OFS;
    assign w_xs1 = {8'h00, x1_q} + C_X_OFS;
    assign w_ys0 = {9'h000, y0_q} + C_Y_OFS;
    assign w_ys1 = {9'h000, y1_q} + C_Y_OFS;

    // Full screen is 12800 pixels, so the area fits 14 bits and bytes fit 15.
    assign w_cols      = {1'b0, x1_q} - {1'b0, x0_q} + 9'd1;
    assign w_rows      = {1'b0, y1_q} - {1'b0, y0_q} + 8'd1;
    assign w_area      = 14'(w_cols) * 14'(w_rows);
    assign w_pix_bytes = {w_area, 1'b0};
    assign w_rem       = pix_cnt_q - 15'd1;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        color_d    = color_q;
        idx_d      = idx_q;
        pix_cnt_d  = pix_cnt_q;
        ack_d      = 2'b00;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_dc_d    = tx_dc_q;
        tx_last_d  = tx_last_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = 2'b00;
                if (init_done && (req != 2'b00)) begin
                    win_d   = w_sel;
                    x0_d    = w_sel ? r1_x0 : r0_x0;
                    x1_d    = w_sel ? r1_x1 : r0_x1;
                    y0_d    = w_sel ? r1_y0 : r0_y0;
                    y1_d    = w_sel ? r1_y1 : r0_y1;
                    color_d = w_sel ? r1_color : r0_color;
                    ack_d   = onehot(w_sel);
                    gnt_d   = onehot(w_sel);
                    rr_d    = ~w_sel;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_bad) begin
                    err_d   = onehot(win_q);
                    state_d = S_IDLE;
                end else begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = C_CMD_CASET;
                    tx_dc_d    = 1'b0;
                    tx_last_d  = 1'b0;
                    state_d    = S_CMD_CA;
                end
            end

            S_CMD_CA: begin
                if (w_accept) begin
                    idx_d     = 2'd0;
                    tx_data_d = par_byte(2'd0, w_xs0, w_xs1);
                    tx_dc_d   = 1'b1;
                    tx_last_d = 1'b0;
                    state_d   = S_PAR_CA;
                end
            end

            S_PAR_CA: begin
                if (w_accept) begin
                    if (idx_q == 2'd3) begin
                        tx_data_d = C_CMD_RASET;
                        tx_dc_d   = 1'b0;
                        tx_last_d = 1'b0;
                        state_d   = S_CMD_RA;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = par_byte(idx_q + 2'd1, w_xs0, w_xs1);
                        tx_last_d = (idx_q == 2'd2);
                    end
                end
            end

            S_CMD_RA: begin
                if (w_accept) begin
                    idx_d     = 2'd0;
                    tx_data_d = par_byte(2'd0, w_ys0, w_ys1);
                    tx_dc_d   = 1'b1;
                    tx_last_d = 1'b0;
                    state_d   = S_PAR_RA;
                end
            end

            S_PAR_RA: begin
                if (w_accept) begin
                    if (idx_q == 2'd3) begin
                        tx_data_d = C_CMD_RAMWR;
                        tx_dc_d   = 1'b0;
                        tx_last_d = 1'b0;
                        state_d   = S_CMD_WR;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = par_byte(idx_q + 2'd1, w_ys0, w_ys1);
                        tx_last_d = (idx_q == 2'd2);
                    end
                end
            end

            S_CMD_WR: begin
                if (w_accept) begin
                    pix_cnt_d = w_pix_bytes;
                    tx_data_d = color_q[15:8];
                    tx_dc_d   = 1'b1;
                    tx_last_d = 1'b0;
                    state_d   = S_PIX;
                end
            end

            // pix_cnt counts bytes still to send including the one on the bus;
            // the total is even, so an even remainder means the high byte.
            S_PIX: begin
                if (w_accept) begin
                    if (pix_cnt_q == 15'd1) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        done_d     = onehot(win_q);
                        state_d    = S_FINISH;
                    end else begin
                        pix_cnt_d = w_rem;
                        tx_data_d = w_rem[0] ? color_q[7:0] : color_q[15:8];
                        tx_last_d = (w_rem == 15'd1);
                    end
                end
            end

            S_FINISH: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            win_q      <= 1'b0;
            x0_q       <= 8'h00;
            x1_q       <= 8'h00;
            y0_q       <= 7'h00;
            y1_q       <= 7'h00;
            color_q    <= 16'h0000;
            idx_q      <= 2'd0;
            pix_cnt_q  <= 15'd0;
            ack_q      <= 2'b00;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_dc_q    <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            win_q      <= win_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            color_q    <= color_d;
            idx_q      <= idx_d;
            pix_cnt_q  <= pix_cnt_d;
            ack_q      <= ack_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_dc_q    <= tx_dc_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign ack      = ack_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_dc    = tx_dc_q;
    assign tx_last  = tx_last_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_fill_scheduler
// Brief    : Directed self-checking bench for lcd_fill_scheduler.
// Revision : 1.0 - initial release
// ============================================================================

module tb_lcd_fill_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [1:0]  req;
    logic [7:0]  r0_x0, r0_x1, r1_x0, r1_x1;
    logic [6:0]  r0_y0, r0_y1, r1_y0, r1_y1;
    logic [15:0] r0_color, r1_color;
    logic [1:0]  ack, gnt, done, err;
    logic        busy, tx_valid, tx_ready, tx_dc, tx_last;
    logic [7:0]  tx_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_fill_scheduler dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .req(req),
        .r0_x0(r0_x0), .r0_x1(r0_x1), .r0_y0(r0_y0), .r0_y1(r0_y1), .r0_color(r0_color),
        .r1_x0(r1_x0), .r1_x1(r1_x1), .r1_y0(r1_y0), .r1_y1(r1_y1), .r1_color(r1_color),
        .ack(ack), .gnt(gnt), .done(done), .err(err), .busy(busy),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_dc(tx_dc), .tx_last(tx_last)
    );

    // Transfer log: {dc, last, data} for every accepted byte.
    logic [9:0] strm[$];
    logic [1:0] acks[$];
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         n_done0 = 0;
    int         n_done1 = 0;
    int         stab_bad = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_byte = 10'h000;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || ({tx_dc, tx_last, tx_data} !== prev_byte)))
                stab_bad <= stab_bad + 1;
            if (tx_valid && tx_ready) begin
                strm.push_back({tx_dc, tx_last, tx_data});
                last_acc_cyc <= cyc;
            end
            if (ack != 2'b00) acks.push_back(ack);
            if (done[0]) n_done0 <= n_done0 + 1;
            if (done[1]) n_done1 <= n_done1 + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_byte  <= {tx_dc, tx_last, tx_data};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " outs"}, {30'd0, tx_valid, tx_dc},
            32'd0);
        chk({tag, " data/last"}, {23'd0, tx_data, tx_last}, 32'd0);
        chk({tag, " ack/gnt/done/err"}, {24'd0, ack, gnt, done, err}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Presents a request, checks ACK timing, then either the first 2Ah byte or the ERR pulse.
    task automatic request(input string tag, input logic which,
                           input logic [7:0] x0, input logic [7:0] x1,
                           input logic [6:0] y0, input logic [6:0] y1,
                           input logic [15:0] col, input logic ok);
        logic [1:0] oh;
        oh = which ? 2'b10 : 2'b01;
        @(negedge clk);
        if (which) begin
            r1_x0 = x0; r1_x1 = x1; r1_y0 = y0; r1_y1 = y1; r1_color = col;
        end else begin
            r0_x0 = x0; r0_x1 = x1; r0_y0 = y0; r0_y1 = y1; r0_color = col;
        end
        req = oh;
        @(negedge clk);
        chk({tag, " ack"}, {30'd0, ack}, {30'd0, oh});
        chk({tag, " gnt"}, {30'd0, gnt}, {30'd0, oh});
        req = 2'b00;
        @(negedge clk);
        if (ok) begin
            chk({tag, " first byte"}, {22'd0, tx_valid, tx_dc, tx_data}, {22'd0, 1'b1, 1'b0, 8'h2A});
        end else begin
            chk({tag, " err pulse"}, {29'd0, tx_valid, err}, {29'd0, 1'b0, oh});
            @(negedge clk);
            chk({tag, " err end"}, {28'd0, busy, tx_valid, err}, 32'd0);
        end
    endtask

    task automatic wait_done(input string tag, input int bound, input logic [1:0] exp_done);
        int k = 0;
        @(negedge clk);
        while (done === 2'b00 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done"}, {30'd0, done}, {30'd0, exp_done});
        chk({tag, " done after last byte"}, last_acc_cyc + 1, cyc);
        chk({tag, " gnt thru done"}, {30'd0, gnt}, {30'd0, exp_done});
        @(negedge clk);
    endtask

    task automatic chk_stream(input string tag, input int base, input logic [87:0] hdr,
                              input logic [15:0] col, input int npix);
        int n = 11 + 2 * npix;
        int e_data = 0;
        int e_dc = 0;
        int e_last = 0;
        logic [7:0] ed;
        logic [9:0] b;
        chk({tag, " length"}, strm.size() - base, n);
        for (int i = 0; i < n && (base + i) < strm.size(); i++) begin
            b  = strm[base + i];
            ed = (i < 11) ? hdr[87 - 8 * i -: 8] : (((i - 11) % 2 == 0) ? col[15:8] : col[7:0]);
            if (b[7:0] !== ed) e_data++;
            if (b[9] !== !(i == 0 || i == 5 || i == 10)) e_dc++;
            if (b[8] !== (i == 4 || i == 9 || i == n - 1)) e_last++;
        end
        chk({tag, " data errors"}, e_data, 0);
        chk({tag, " dc errors"}, e_dc, 0);
        chk({tag, " last errors"}, e_last, 0);
    endtask

    initial begin
        int base;
        int abase;
        int d0;
        int d1;
        int k;

        rst_n = 1'b0; init_done = 1'b0; req = 2'b00; tx_ready = 1'b0;
        r0_x0 = 8'd0; r0_x1 = 8'd0; r0_y0 = 7'd0; r0_y1 = 7'd0; r0_color = 16'h0;
        r1_x0 = 8'd0; r1_x1 = 8'd0; r1_y0 = 7'd0; r1_y1 = 7'd0; r1_color = 16'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1; init_done = 1'b1; tx_ready = 1'b1;
        @(negedge clk);

        // Full screen fill
        base = strm.size(); d0 = n_done0;
        request("full", 1'b0, 8'd0, 8'd159, 7'd0, 7'd79, 16'hF800, 1'b1);
        wait_done("full", 30000, 2'b01);
        chk_stream("full", base, 88'h2A_00_01_00_A0_2B_00_1A_00_69_2C, 16'hF800, 12800);
        chk("full done once", n_done0 - d0, 1);

        // Single pixel from requester 1
        base = strm.size(); d1 = n_done1;
        request("single", 1'b1, 8'd5, 8'd5, 7'd3, 7'd3, 16'h1234, 1'b1);
        wait_done("single", 100, 2'b10);
        chk_stream("single", base, 88'h2A_00_06_00_06_2B_00_1D_00_1D_2C, 16'h1234, 1);
        chk("single done once", n_done1 - d1, 1);

        // Contention: both held from reset release
        @(negedge clk);
        rst_n = 1'b0;
        r0_x0 = 8'd0; r0_x1 = 8'd0; r0_y0 = 7'd0; r0_y1 = 7'd0; r0_color = 16'hAAAA;
        r1_x0 = 8'd1; r1_x1 = 8'd1; r1_y0 = 7'd1; r1_y1 = 7'd1; r1_color = 16'h5555;
        req = 2'b11;
        abase = acks.size(); d0 = n_done0; d1 = n_done1;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (acks.size() - abase < 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        req = 2'b00;
        repeat (40) @(negedge clk);
        chk("contention ack count", acks.size() - abase, 4);
        for (int i = 0; i < 4 && (abase + i) < acks.size(); i++)
            chk("contention order", {30'd0, acks[abase + i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        chk("contention done0", n_done0 - d0, 2);
        chk("contention done1", n_done1 - d1, 2);

        // Rejects: X1 off-screen, then Y0 > Y1
        base = strm.size();
        request("rej x1", 1'b0, 8'd0, 8'd160, 7'd0, 7'd0, 16'h1111, 1'b0);
        request("rej y", 1'b0, 8'd0, 8'd0, 7'd10, 7'd9, 16'h2222, 1'b0);
        repeat (3) @(negedge clk);
        chk("reject no bytes", strm.size() - base, 0);

        // Backpressure on a 4x2 fill
        base = strm.size();
        tx_ready = 1'b0;
        request("bp", 1'b0, 8'd2, 8'd5, 7'd1, 7'd2, 16'h07E0, 1'b1);
        k = 0;
        while (done === 2'b00 && k < 2000) begin
            @(negedge clk);
            if (done === 2'b00) tx_ready = 1'($urandom_range(0, 1));
            k++;
        end
        chk("bp done", {30'd0, done}, 32'd1);
        @(negedge clk);
        tx_ready = 1'b1;
        chk_stream("bp", base, 88'h2A_00_03_00_06_2B_00_1B_00_1C_2C, 16'h07E0, 8);
        chk("bp stability", stab_bad, 0);

        // Reset in the middle of PIX, then blocked by INIT_DONE
        request("midrst", 1'b0, 8'd0, 8'd159, 7'd0, 7'd79, 16'hF800, 1'b1);
        repeat (40) @(negedge clk);
        chk("midrst in pix", {31'd0, tx_dc}, 32'd1);
        rst_n = 1'b0; init_done = 1'b0;
        r0_x0 = 8'd7; r0_x1 = 8'd8; r0_y0 = 7'd7; r0_y1 = 7'd8; r0_color = 16'h001F;
        req = 2'b01;
        #1;
        chk_reset_outputs("midrst async");
        @(negedge clk);
        rst_n = 1'b1;
        abase = acks.size();
        repeat (10) @(negedge clk);
        chk("no ack without init", acks.size() - abase, 0);
        chk("no valid without init", {31'd0, tx_valid}, 32'd0);
        base = strm.size();
        init_done = 1'b1;
        @(negedge clk);
        chk("restart ack", {30'd0, ack}, 32'd1);
        req = 2'b00;
        @(negedge clk);
        chk("restart first byte", {22'd0, tx_valid, tx_dc, tx_data}, {22'd0, 1'b1, 1'b0, 8'h2A});
        wait_done("restart", 200, 2'b01);
        chk_stream("restart", base, 88'h2A_00_08_00_09_2B_00_21_00_22_2C, 16'h001F, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
